// File: rtl/eth_f_sync_pkg.sv
// Shared types, limits and helpers for the multibit status synchronizer family.
package eth_f_sync_pkg;

  localparam int unsigned DEPTH_MIN  = 2;
  localparam int unsigned STABLE_MIN = 1;
  localparam int unsigned GRAY_MAX_W = 256;

  typedef enum logic {
    FLUSH = 1'b0,
    TRACK = 1'b1
  } sync_state_e;

  // Gray-to-binary decode; narrower vectors are zero-extended by the caller.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/eth_f_sync_chain.sv
// WIDTH x DEPTH synchronizer flop chain; the d input is a false path from any clock.
module eth_f_sync_chain #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* async_reg = "true", dont_touch = "true" *)
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage[i] <= RST_VALUE;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/eth_f_multibit_sync_qual.sv
// Multibit status synchronizer with stability qualification, optional gray decode,
// change strobe/mask and a saturating update counter.
module eth_f_multibit_sync_qual
  import eth_f_sync_pkg::*;
#(
  parameter int unsigned      WIDTH         = 32,
  parameter int unsigned      DEPTH         = 3,
  parameter int unsigned      STABLE_CYCLES = 4,
  parameter int unsigned      GRAY          = 0,
  parameter logic [WIDTH-1:0] RST_VALUE     = '0,
  parameter int unsigned      CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             change_pulse,
  output logic [WIDTH-1:0] change_mask,
  output logic [CNT_W-1:0] upd_cnt
);

  localparam int unsigned NW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned FW = $clog2(DEPTH + 1);

  if (DEPTH < DEPTH_MIN) begin : g_depth_chk
    $error("DEPTH must be >= %0d", DEPTH_MIN);
  end
  if (STABLE_CYCLES < STABLE_MIN) begin : g_stable_chk
    $error("STABLE_CYCLES must be >= %0d", STABLE_MIN);
  end
  if ((GRAY != 0) && (WIDTH > GRAY_MAX_W)) begin : g_gray_chk
    $error("WIDTH must be <= %0d when GRAY=1", GRAY_MAX_W);
  end

  sync_state_e      state, state_nxt;
  logic [WIDTH-1:0] s, c, c_nxt, c_dec;
  logic [NW-1:0]    n, n_nxt;
  logic [FW-1:0]    f, f_nxt;
  logic             qualify_c;

  eth_f_sync_chain #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RST_VALUE (RST_VALUE)
  ) u_chain (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (s)
  );

  if (GRAY != 0) begin : g_gray
    assign c_dec = WIDTH'(gray2bin(GRAY_MAX_W'(c)));
  end else begin : g_bin
    assign c_dec = c;
  end

  // FLUSH lets RST_VALUE drain out of the chain before any candidate is tracked.
  always_comb begin
    state_nxt = state;
    c_nxt     = c;
    n_nxt     = n;
    f_nxt     = f;
    qualify_c = 1'b0;
    case (state)
      FLUSH: begin
        f_nxt = f + FW'(1);
        if (f == FW'(DEPTH - 1)) begin
          state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (s != c) begin
          c_nxt = s;
          n_nxt = NW'(1);
        end else if (n < NW'(STABLE_CYCLES)) begin
          n_nxt = n + NW'(1);
        end
        qualify_c = (n == NW'(STABLE_CYCLES)) && (s == c) &&
                    ((c_dec != dout) || !dout_valid);
      end
      default: state_nxt = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FLUSH;
      c     <= RST_VALUE;
      n     <= '0;
      f     <= '0;
    end else begin
      state <= state_nxt;
      c     <= c_nxt;
      n     <= n_nxt;
      f     <= f_nxt;
    end
  end

  // Publish stage: the first qualification always strobes, even if the value equals reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout         <= RST_VALUE;
      dout_valid   <= 1'b0;
      change_pulse <= 1'b0;
      change_mask  <= '0;
      upd_cnt      <= '0;
    end else begin
      change_pulse <= qualify_c;
      change_mask  <= qualify_c ? (dout ^ c_dec) : '0;
      if (qualify_c) begin
        dout       <= c_dec;
        dout_valid <= 1'b1;
        if (upd_cnt != '1) begin
          upd_cnt <= upd_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_f_multibit_sync_qual.sv
// Scoreboard bench: a binary instance (CNT_W=4) and a gray instance share clk/reset.
`timescale 1ns/1ps
module tb_eth_f_multibit_sync_qual;

  localparam int unsigned W   = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned CWG = 16;

  typedef struct {
    logic [W-1:0]   dout;
    logic [W-1:0]   mask;
    logic [CWG-1:0] cnt;
    int unsigned    at_edge;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   din, din_g;
  logic [W-1:0]   dout, dout_g, change_mask, change_mask_g;
  logic           dout_valid, dout_valid_g, change_pulse, change_pulse_g;
  logic [CW-1:0]  upd_cnt;
  logic [CWG-1:0] upd_cnt_g;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  exp_t        q_main[$];
  exp_t        q_gray[$];
  logic [W-1:0] mdl_dout, mdl_dout_g;
  int unsigned  mdl_cnt, mdl_cnt_g;

  eth_f_multibit_sync_qual #(
    .WIDTH(W), .DEPTH(3), .STABLE_CYCLES(4), .GRAY(0), .RST_VALUE(8'h00), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout), .dout_valid(dout_valid),
    .change_pulse(change_pulse), .change_mask(change_mask), .upd_cnt(upd_cnt)
  );

  eth_f_multibit_sync_qual #(
    .WIDTH(W), .DEPTH(3), .STABLE_CYCLES(4), .GRAY(1), .RST_VALUE(8'h00), .CNT_W(CWG)
  ) u_dut_gray (
    .clk(clk), .reset(reset), .din(din_g), .dout(dout_g), .dout_valid(dout_valid_g),
    .change_pulse(change_pulse_g), .change_mask(change_mask_g), .upd_cnt(upd_cnt_g)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int i = 1; i < int'(W); i++) b = b ^ (g >> i);
    return b;
  endfunction

  task automatic push_main(input logic [W-1:0] v, input int unsigned at);
    exp_t e;
    mdl_cnt   = (mdl_cnt >= 15) ? 15 : mdl_cnt + 1;
    e.dout    = v;
    e.mask    = mdl_dout ^ v;
    e.cnt     = CWG'(mdl_cnt);
    e.at_edge = at;
    mdl_dout  = v;
    q_main.push_back(e);
  endtask

  task automatic push_gray(input logic [W-1:0] v, input int unsigned at);
    exp_t e;
    mdl_cnt_g  = mdl_cnt_g + 1;
    e.dout     = v;
    e.mask     = mdl_dout_g ^ v;
    e.cnt      = CWG'(mdl_cnt_g);
    e.at_edge  = at;
    mdl_dout_g = v;
    q_gray.push_back(e);
  endtask

  task automatic model_reset();
    q_main.delete();
    q_gray.delete();
    mdl_dout = '0; mdl_dout_g = '0;
    mdl_cnt  = 0;  mdl_cnt_g  = 0;
  endtask

  // Scoreboard monitors: every pulse must match the head of its queue, at the expected edge.
  always @(negedge clk) begin
    if (!reset) begin
      exp_t e;
      n_checks++;
      if (change_pulse) begin
        if (q_main.size() == 0) begin
          n_fail++;
          $display("FAIL main_unexpected_pulse: got pulse dout=%h at edge %0d, expected none", dout, cyc);
        end else begin
          e = q_main.pop_front();
          if (dout !== e.dout || change_mask !== e.mask || upd_cnt !== e.cnt[CW-1:0] || cyc != e.at_edge) begin
            n_fail++;
            $display("FAIL main_pulse: got dout=%h mask=%h cnt=%0d edge=%0d, expected dout=%h mask=%h cnt=%0d edge=%0d",
                     dout, change_mask, upd_cnt, cyc, e.dout, e.mask, e.cnt[CW-1:0], e.at_edge);
          end
        end
      end else if (change_mask !== '0) begin
        n_fail++;
        $display("FAIL main_idle_mask: got %h, expected 00", change_mask);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      exp_t e;
      n_checks++;
      if (change_pulse_g) begin
        if (q_gray.size() == 0) begin
          n_fail++;
          $display("FAIL gray_unexpected_pulse: got pulse dout=%h at edge %0d, expected none", dout_g, cyc);
        end else begin
          e = q_gray.pop_front();
          if (dout_g !== e.dout || change_mask_g !== e.mask || upd_cnt_g !== e.cnt || cyc != e.at_edge) begin
            n_fail++;
            $display("FAIL gray_pulse: got dout=%h mask=%h cnt=%0d edge=%0d, expected dout=%h mask=%h cnt=%0d edge=%0d",
                     dout_g, change_mask_g, upd_cnt_g, cyc, e.dout, e.mask, e.cnt, e.at_edge);
          end
        end
      end else if (change_mask_g !== '0) begin
        n_fail++;
        $display("FAIL gray_idle_mask: got %h, expected 00", change_mask_g);
      end
    end
  end

  task automatic wait_drain(input int unsigned max_cyc);
    for (int i = 0; i < int'(max_cyc); i++) begin
      if (q_main.size() == 0 && q_gray.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (q_main.size() != 0 || q_gray.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending pulses, expected 0/0", q_main.size(), q_gray.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dout, dout_valid, change_pulse, change_mask, upd_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_main: got dout=%h v=%b p=%b m=%h c=%h, expected all zero",
               dout, dout_valid, change_pulse, change_mask, upd_cnt);
    end
    n_checks++;
    if ({dout_g, dout_valid_g, change_pulse_g, change_mask_g, upd_cnt_g} !== '0) begin
      n_fail++;
      $display("FAIL reset_gray: got dout=%h v=%b p=%b m=%h c=%h, expected all zero",
               dout_g, dout_valid_g, change_pulse_g, change_mask_g, upd_cnt_g);
    end
  endtask

  task automatic release_and_lock(input logic [W-1:0] v, input logic [W-1:0] vg, input string tag);
    int unsigned k;
    reset = 1'b0;
    k = cyc;
    push_main(v, k + 8);
    push_gray(vg, k + 8);
    repeat (7) @(negedge clk);
    n_checks++;
    if (dout_valid !== 1'b0 || dout_valid_g !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_valid_early: got %b/%b at edge 7, expected 0/0", tag, dout_valid, dout_valid_g);
    end
    @(negedge clk);
    n_checks++;
    if (dout_valid !== 1'b1 || dout_valid_g !== 1'b1 || dout !== v || dout_g !== vg) begin
      n_fail++;
      $display("FAIL %s_lock: got v=%b/%b dout=%h/%h at edge 8, expected 1/1 %h/%h",
               tag, dout_valid, dout_valid_g, dout, dout_g, v, vg);
    end
    wait_drain(4);
  endtask

  task automatic test_cold_lock();
    release_and_lock(8'hA5, g2b(8'h0C), "cold");
  endtask

  task automatic test_step();
    din = 8'h3C;
    push_main(8'h3C, cyc + 8);
    repeat (8) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (change_pulse !== 1'b0 || dout !== 8'h3C) begin
      n_fail++;
      $display("FAIL step_width: got pulse=%b dout=%h, expected 0 3c", change_pulse, dout);
    end
    wait_drain(4);
  endtask

  task automatic test_chatter();
    int unsigned last_k;
    for (int i = 0; i < 25; i++) begin
      din = (i % 2 == 0) ? 8'hFF : 8'h00;
      if (i == 24) begin
        last_k = cyc;
        push_main(8'hFF, last_k + 8);
      end
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (dout !== 8'h3C) begin
      n_fail++;
      $display("FAIL chatter_hold: got %h, expected 3c", dout);
    end
    wait_drain(10);
  endtask

  task automatic test_glitch();
    din = 8'h3C;
    push_main(8'h3C, cyc + 8);
    wait_drain(12);
    din = 8'h3D;
    repeat (2) @(negedge clk);
    din = 8'h3C;
    repeat (14) @(negedge clk);
    n_checks++;
    if (dout !== 8'h3C || upd_cnt !== CW'(mdl_cnt)) begin
      n_fail++;
      $display("FAIL glitch_revert: got dout=%h cnt=%0d, expected 3c %0d", dout, upd_cnt, mdl_cnt);
    end
  endtask

  task automatic test_gray();
    din_g = 8'h0D;
    push_gray(g2b(8'h0D), cyc + 8);
    wait_drain(12);
    n_checks++;
    if (dout_g !== 8'h09) begin
      n_fail++;
      $display("FAIL gray_decode: got %h, expected 09", dout_g);
    end
  endtask

  task automatic test_reset_mid();
    din = 8'h5A;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({dout, dout_valid, change_pulse, upd_cnt, dout_g, dout_valid_g, upd_cnt_g} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got dout=%h v=%b p=%b c=%h gdout=%h gv=%b gc=%h, expected all zero",
               dout, dout_valid, change_pulse, upd_cnt, dout_g, dout_valid_g, upd_cnt_g);
    end
    release_and_lock(8'h5A, g2b(8'h0D), "relock");
  endtask

  task automatic test_saturation();
    logic [W-1:0] v;
    for (int i = 0; i < 20; i++) begin
      v = W'(i * 37 + 11);
      din = v;
      push_main(v, cyc + 8);
      repeat (9) @(negedge clk);
    end
    wait_drain(12);
    n_checks++;
    if (upd_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL saturation: got %h, expected f", upd_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    din   = 8'hA5;
    din_g = 8'h0C;
    model_reset();
    test_reset();
    test_cold_lock();
    test_step();
    test_chatter();
    test_glitch();
    test_gray();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_f_multibit_sync_qual.md
# eth_f_multibit_sync_qual

Parametrised successor to the per-bit multibit status synchronizer. It brings an asynchronous multibit status vector into the `clk` domain through a DEPTH-stage flop chain. A stability qualifier then publishes the vector only after it has held for STABLE_CYCLES consecutive cycles, so sampling skew across bits cannot produce a torn word. It adds optional gray-to-binary decode, a change strobe with per-bit mask, and a saturating update counter. It sits on the HSSI/MAC status path in front of CSR readback and interrupt logic.

## Interface
- WIDTH, 32: status vector width (≥1).
- DEPTH, 3: synchronizer stages (≥2).
- STABLE_CYCLES, 4: consecutive equal samples required before publishing (≥1).
- GRAY, 0: 1 = din is gray-coded; dout is the binary decode.
- RST_VALUE, {WIDTH{1'b0}}: reset value of sync chain, candidate and dout.
- CNT_W, 16: width of upd_cnt.

- clk, input, 1: destination clock; the only clock.
- reset, input, 1: synchronous, active-high reset.
- din, input, WIDTH: asynchronous status vector; no timing relation to clk.
- dout, output, WIDTH: qualified, synchronized vector (decoded if GRAY=1).
- dout_valid, output, 1: first qualified value has been published since reset.
- change_pulse, output, 1: one-cycle strobe, asserted in the cycle dout takes a new value.
- change_mask, output, WIDTH: old dout XOR new dout, valid while change_pulse=1, 0 otherwise.
- upd_cnt, output, CNT_W: count of change_pulse assertions, saturating at all-ones.

## Operation
- Internal state:
  - Sync chain; S is the output of the last stage.
  - Candidate register C.
  - Stability counter N, width $clog2(STABLE_CYCLES+1).
  - Flush counter F.
  - FSM {FLUSH, TRACK}.
- Reset:
  - Chain and C = RST_VALUE; N = 0; F = 0; state = FLUSH.
  - dout = RST_VALUE; dout_valid = 0; change_pulse = 0; change_mask = 0; upd_cnt = 0.
- FLUSH:
  - The chain shifts; C and N hold.
  - F increments each edge. After DEPTH edges, go to TRACK.
  - No qualification happens in FLUSH.
- TRACK, evaluated every edge:
  - If S ≠ C: C ← S, N ← 1.
  - Else if N < STABLE_CYCLES: N ← N+1.
  - Qualify when N == STABLE_CYCLES and S == C and (C_dec ≠ dout or dout_valid == 0). C_dec is gray2bin(C) if GRAY=1, else C.
  - On qualify: dout ← C_dec; dout_valid ← 1; change_pulse ← 1; change_mask ← dout XOR C_dec; upd_cnt ← upd_cnt+1 unless all-ones.
- The first qualification always pulses, even when C_dec equals RST_VALUE; change_mask is then 0.
- din that changes and reverts within the window: C returns to the published value, so no pulse.
- din toggling faster than STABLE_CYCLES: dout holds its last value indefinitely, with no pulse.
- Reset has priority over every event. Reset mid-count or mid-pulse returns all outputs to reset values on the next edge and re-enters FLUSH.

## Timing
- All outputs are registered; there is no combinational path from din.
- Latency: a din change captured by stage 1 at edge e appears on dout and change_pulse at edge e+DEPTH+STABLE_CYCLES. With defaults, that is 7 edges.
- After reset release (first edge with reset=0 is edge 1):
  - dout_valid rises at edge DEPTH+STABLE_CYCLES+1, which is 8 for defaults.
  - This holds regardless of whether din equals RST_VALUE.
- change_pulse is exactly one cycle wide. Back-to-back pulses are at least STABLE_CYCLES cycles apart.
- STABLE_CYCLES=1: dout updates the edge after C captures a new S.

## Structure
- Shared package eth_f_sync_pkg holds:
  - the FSM state typedef {FLUSH, TRACK};
  - the function gray2bin(width-generic);
  - the minimum-parameter constants (DEPTH_MIN=2, STABLE_MIN=1).
- One sub-module, eth_f_sync_chain:
  - a WIDTH × DEPTH flop chain with synchronous active-high reset to RST_VALUE;
  - it carries the CDC/false-path synthesis attributes.
- Qualifier, FSM and counters live in the top module.
- Elaboration-time check: DEPTH ≥ 2, STABLE_CYCLES ≥ 1.

## Test plan
- Cold lock. WIDTH=8, defaults, din=0xA5 held through reset release.
  - Expect: dout_valid and change_pulse at edge 8; dout=0xA5; change_mask=0xA5; upd_cnt=1.
- Step. din 0xA5→0x3C, captured at edge e.
  - Expect: dout=0x3C at e+7; one-cycle pulse; change_mask=0x99; upd_cnt=2.
- Chatter. din alternates 0x00/0xFF every 2 cycles for 50 cycles, then holds 0xFF.
  - Expect: no pulse during chatter; dout holds prior value; then dout=0xFF 7 edges after the final change.
- Glitch revert. din 0x3C→0x3D for 2 cycles, then back to 0x3C (STABLE_CYCLES=4).
  - Expect: no change_pulse; dout stays 0x3C; upd_cnt unchanged.
- Gray decode. GRAY=1; din=0x0C, then 0x0D.
  - Expect: dout=0x08 then 0x09; change_mask=0x01.
- Reset and saturation.
  - Reset asserted 2 cycles into a qualification window: next edge shows dout=RST_VALUE, valid=0, upd_cnt=0; relock at edge 8.
  - CNT_W=4 with 20 qualified changes: upd_cnt stops at 0xF.
